imem_loader: RTL and testbench

- Sequential write-side companion to the 256-word, 32-bit instruction memory.
- Receives a program image as a byte stream with a valid/ready handshake.
- Assembles big-endian 32-bit words and drives the instruction memory's write port with word-aligned byte addresses.
- Holds the processor stalled (cpu_hold) while a load is in progress.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
//   byte_data/byte_valid/byte_ready : program image stream with a valid/ready handshake
//   mem_we/mem_addr/mem_wdata        : instruction-memory write port (byte addresses)
// Modports: slave = the loader itself, master = the stream source / memory side.
interface imem_loader_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_data, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_data, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: loads a program image into the instruction memory from a byte stream.
// Stream format: big-endian word count header, then count big-endian 32-bit words.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require one trailer byte that must
// equal the XOR of all data bytes; a mismatch ends the load in the error state.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   start_i      : single-cycle pulse, honoured only when idle, done or in error
//   bus          : stream handshake and memory write port (imem_loader_if.slave)
//   cpu_hold_o   : pipeline stall request while a load is in progress or has failed
//   done_o       : last load completed successfully
//   error_o      : last load aborted
module imem_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned HDR_BYTES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  imem_loader_if.slave bus,
  output logic         cpu_hold_o,
  output logic         done_o,
  output logic         error_o
);

  localparam int unsigned CntW  = 8 * HDR_BYTES;
  localparam int unsigned Depth = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    StIdle, StHdrHi, StHdrLo, StData, StWrite, StDone, StErr, StChk
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [1:0]          lane_q, lane_d;
  logic [23:0]         word_q, word_d;   // first three bytes of the word being assembled
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic ready, fire;
  state_e last_next;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign last_next = StChk;
  assign ready = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData) ||
                 (state_q == StChk);
`else
  assign last_next = StDone;
  assign ready = (state_q == StHdrHi) || (state_q == StHdrLo) || (state_q == StData);
`endif

  assign fire = bus.byte_valid & ready;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    word_d  = word_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start_i) begin
          state_d = StHdrHi;
          idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StHdrHi: begin
        if (fire) begin
          count_d = CntW'(bus.byte_data);
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        if (fire) begin
          count_d = {count_q[CntW-9:0], bus.byte_data};
          lane_d  = '0;
          if (count_d == '0) begin
            state_d = last_next;
          end else if (32'(count_d) > Depth) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (fire) begin
          word_d = {word_q[15:0], bus.byte_data};
          lane_d = lane_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.byte_data;
`endif
          if (lane_q == 2'd3) begin
            // Capture address and word here so they hold steady outside the write cycle.
            state_d = StWrite;
            addr_d  = 32'({idx_q, 2'b00});
            wdata_d = {word_q, bus.byte_data};
          end
        end
      end
      StWrite: begin
        // The index is not advanced past the last word so a full memory never wraps it.
        if (CntW'(idx_q) == count_q - CntW'(1)) begin
          state_d = last_next;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StData;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (fire) begin
          state_d = (bus.byte_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      lane_q  <= lane_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    bus.byte_ready = ready;
    bus.mem_we     = (state_q == StWrite);
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = wdata_q;
    cpu_hold_o     = (state_q != StIdle) && (state_q != StDone);
    done_o         = (state_q == StDone);
    error_o        = (state_q == StErr);
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader. Expected writes and final
// status are derived from the stream format; a monitor pops writes as the DUT issues them.
module tb_imem_loader;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if bus ();

  imem_loader #(.ADDR_W(ADDR_W), .HDR_BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .bus       (bus.slave),
    .cpu_hold_o(cpu_hold),
    .done_o    (done),
    .error_o   (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && bus.mem_we === 1'b1) begin
      wr_t e;
      check("wr_ready_low", 32'(bus.byte_ready), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = sb.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit poke);
    int unsigned waited;
    repeat (gap) begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    if (poke) start = 1'b1;
    waited = 0;
    while (bus.byte_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (bus.byte_ready !== 1'b1) begin
      checks++;
      $display("FAIL send_timeout: byte_ready stayed 0 for %0d cycles, required 1", waited);
    end else begin
      @(posedge clk);
    end
    #1;
    bus.byte_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Reference: header gives word count; words are big-endian groups of four data bytes.
  task automatic do_load(input logic [7:0] s[$], input bit toggle, input bit poke);
    int unsigned cnt;
    bit ok;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
`endif
    cnt = 32'({s[0], s[1]});
    ok  = 1'b1;
    if (cnt > DEPTH) begin
      ok = 1'b0;
    end else begin
      for (int w = 0; w < int'(cnt); w++) begin
        sb.push_back({32'(w * 4), s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = x ^ s[2+4*w] ^ s[3+4*w] ^ s[4+4*w] ^ s[5+4*w];
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ok = (s[2+4*cnt] == x);
`endif
    end
    pulse_start();
    check("hold_after_start", 32'(cpu_hold), 32'd1);
    check("done_cleared", 32'(done), 32'd0);
    check("error_cleared", 32'(error), 32'd0);
    for (int i = 0; i < s.size(); i++) begin
      send_byte(s[i], toggle ? 1 : 0, poke && (i + 1 < s.size()) && (i % 37 == 5));
    end
    repeat (3) @(negedge clk);
    check("end_done", 32'(done), 32'(ok));
    check("end_error", 32'(error), 32'(!ok));
    check("end_hold", 32'(cpu_hold), 32'(!ok));
    check("end_ready", 32'(bus.byte_ready), 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(bus.byte_ready), 32'd0);
    check("rst_we", 32'(bus.mem_we), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
  endtask

  task automatic add_trailer(inout logic [7:0] s[$], input int unsigned cnt, input bit corrupt);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < int'(cnt) * 4; i++) x = x ^ s[2+i];
    s.push_back(corrupt ? ~x : x);
`else
    if (corrupt && cnt > DEPTH) s.delete();
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    int unsigned cnt;
    bus.byte_data  = 8'h00;
    bus.byte_valid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Single word.
    s = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    add_trailer(s, 1, 1'b0);
    do_load(s, 1'b0, 1'b0);

    // Two words with byte_valid toggling.
    s = {8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
    add_trailer(s, 2, 1'b0);
    do_load(s, 1'b1, 1'b0);

    // Empty image.
    s = {8'h00, 8'h00};
    add_trailer(s, 0, 1'b0);
    do_load(s, 1'b0, 1'b0);

    // Oversized header, then a random oversized one.
    s = {8'h01, 8'h01};
    do_load(s, 1'b0, 1'b0);
    cnt = $urandom_range(65535, DEPTH + 1);
    s = {8'(cnt >> 8), 8'(cnt)};
    do_load(s, 1'b1, 1'b0);

    // Random short images.
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(6, 1);
      s = {8'(cnt >> 8), 8'(cnt)};
      for (int i = 0; i < int'(cnt) * 4; i++) s.push_back(8'($urandom));
      add_trailer(s, cnt, r == 3);
      do_load(s, 1'($urandom_range(1, 0)), 1'b0);
    end

    // Full memory with start pulses mid-load.
    s = {8'h01, 8'h00};
    for (int i = 0; i < int'(DEPTH) * 4; i++) s.push_back(8'($urandom));
    add_trailer(s, DEPTH, 1'b0);
    do_load(s, 1'b0, 1'b1);

    // Reset in the middle of a data word.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    s = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    add_trailer(s, 1, 1'b0);
    do_load(s, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer: word is still written, load ends in error.
    s = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    do_load(s, 1'b0, 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
